// File: rtl/i2c_byte_arbiter_if.sv
// Bundle between the arbiter, its requesters and one i2c_master_byte_ctrl
// command port. The arbiter connects through the slave modport; the
// environment (requesters and byte controller) uses the master modport.
interface i2c_byte_arbiter_if #(
    parameter int N_REQ = 2,
    parameter int DW    = 8
);
    // requester side
    logic [N_REQ-1:0]    req_i;
    logic [N_REQ-1:0]    gnt_o;
    logic [N_REQ-1:0]    cmd_valid_i;
    logic [N_REQ-1:0]    cmd_start_i;
    logic [N_REQ-1:0]    cmd_stop_i;
    logic [N_REQ-1:0]    cmd_read_i;
    logic [N_REQ-1:0]    cmd_write_i;
    logic [N_REQ-1:0]    cmd_ack_in_i;
    logic [N_REQ*DW-1:0] cmd_din_i;
    logic [N_REQ-1:0]    cmd_done_o;
    logic [N_REQ-1:0]    cmd_err_o;
    logic [DW-1:0]       rd_data_o;
    logic                ack_out_o;

    // byte controller side
    logic                m_start_o;
    logic                m_stop_o;
    logic                m_read_o;
    logic                m_write_o;
    logic                m_ack_in_o;
    logic [DW-1:0]       m_din_o;
    logic                m_cmd_ack_i;
    logic                m_ack_out_i;
    logic [DW-1:0]       m_dout_i;
    logic                m_al_i;

    modport slave (
        input  req_i, cmd_valid_i, cmd_start_i, cmd_stop_i, cmd_read_i,
               cmd_write_i, cmd_ack_in_i, cmd_din_i,
               m_cmd_ack_i, m_ack_out_i, m_dout_i, m_al_i,
        output gnt_o, cmd_done_o, cmd_err_o, rd_data_o, ack_out_o,
               m_start_o, m_stop_o, m_read_o, m_write_o, m_ack_in_o, m_din_o
    );

    modport master (
        output req_i, cmd_valid_i, cmd_start_i, cmd_stop_i, cmd_read_i,
               cmd_write_i, cmd_ack_in_i, cmd_din_i,
               m_cmd_ack_i, m_ack_out_i, m_dout_i, m_al_i,
        input  gnt_o, cmd_done_o, cmd_err_o, rd_data_o, ack_out_o,
               m_start_o, m_stop_o, m_read_o, m_write_o, m_ack_in_o, m_din_o
    );
endinterface

// File: rtl/i2c_byte_arbiter.sv
// Round-robin sharing of one i2c_master_byte_ctrl command port between
// N_REQ requesters. A grant is held for a whole I2C transaction (START to
// STOP); a bus left open by an owner that walks away or times out is closed
// with an internally issued STOP.
//
// state | meaning
// IDLE  | no owner, scanning req_i from the round-robin pointer
// OWN   | owner granted, waiting for its next command (or its release)
// BUSY  | command on the byte controller, waiting for cmd_ack / AL / timeout
// FLUSH | internal STOP on the byte controller to close an abandoned bus
module i2c_byte_arbiter #(
    parameter int N_REQ          = 2,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                 clk_i,
    input  logic                 arstn_i,
    i2c_byte_arbiter_if.slave    bus
);
    localparam int DW = DATA_WIDTH;
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    // packed byte-ctrl command bits {start, stop, read, write, ack_in}
    localparam logic [4:0] M_NONE = 5'b00000;
    localparam logic [4:0] M_STOP = 5'b01000;
    localparam int B_START = 4;
    localparam int B_STOP  = 3;

    typedef enum logic [1:0] {S_IDLE, S_OWN, S_BUSY, S_FLUSH} state_t;

    state_t           r_state, w_state_nxt;
    logic [IW-1:0]    r_ptr, w_ptr_nxt;
    logic [IW-1:0]    r_idx, w_idx_nxt;
    logic [N_REQ-1:0] r_gnt, w_gnt_nxt;
    logic             r_open, w_open_nxt;
    logic [CW-1:0]    r_cnt, w_cnt_nxt;
    logic [4:0]       r_m_cmd, w_m_cmd_nxt;
    logic [DW-1:0]    r_m_din, w_m_din_nxt;
    logic [N_REQ-1:0] r_done, w_done_nxt;
    logic [N_REQ-1:0] r_err, w_err_nxt;
    logic [DW-1:0]    r_rd_data, w_rd_data_nxt;
    logic             r_ack_out, w_ack_out_nxt;

    logic             w_found;
    logic [IW-1:0]    w_win;
    logic [IW-1:0]    w_j;
    logic [IW-1:0]    w_win_next;

    logic             w_c_valid, w_c_start, w_c_stop, w_c_read, w_c_write, w_c_ack_in;
    logic [DW-1:0]    w_c_din;
    logic             w_legal;
    logic             w_owner_req;
    logic             w_timeout;

    // Round-robin scan: first requester at or above r_ptr, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_j     = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (int'(r_ptr) + k >= N_REQ) begin
                w_j = IW'(int'(r_ptr) + k - N_REQ);
            end else begin
                w_j = IW'(int'(r_ptr) + k);
            end
            if (!w_found && bus.req_i[w_j]) begin
                w_found = 1'b1;
                w_win   = w_j;
            end
        end
        w_win_next = (w_win == IW'(N_REQ - 1)) ? '0 : w_win + IW'(1);
    end

    // Decode the owner's command slot; start is only meaningful with write.
    always_comb begin
        w_c_valid   = bus.cmd_valid_i[r_idx];
        w_c_start   = bus.cmd_start_i[r_idx];
        w_c_stop    = bus.cmd_stop_i[r_idx];
        w_c_read    = bus.cmd_read_i[r_idx];
        w_c_write   = bus.cmd_write_i[r_idx];
        w_c_ack_in  = bus.cmd_ack_in_i[r_idx];
        w_c_din     = bus.cmd_din_i[int'(r_idx)*DW +: DW];
        w_owner_req = bus.req_i[r_idx];
        w_legal     = ((w_c_read ^ w_c_write) && (!w_c_start || w_c_write)) ||
                      (w_c_stop && !w_c_start && !w_c_read && !w_c_write);
        w_timeout   = (r_cnt == CW'(TIMEOUT_CYCLES - 1));
    end

    // Next-state and next-output logic; pulses default low every cycle.
    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_idx_nxt     = r_idx;
        w_gnt_nxt     = r_gnt;
        w_open_nxt    = r_open;
        w_cnt_nxt     = r_cnt;
        w_m_cmd_nxt   = r_m_cmd;
        w_m_din_nxt   = r_m_din;
        w_done_nxt    = '0;
        w_err_nxt     = '0;
        w_rd_data_nxt = r_rd_data;
        w_ack_out_nxt = r_ack_out;

        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt      = S_OWN;
                    w_idx_nxt        = w_win;
                    w_gnt_nxt        = '0;
                    w_gnt_nxt[w_win] = 1'b1;
                    w_ptr_nxt        = w_win_next;
                end
            end
            S_OWN: begin
                // release takes precedence over a command in the same cycle
                if (!w_owner_req) begin
                    if (r_open) begin
                        w_state_nxt = S_FLUSH;
                        w_m_cmd_nxt = M_STOP;
                        w_m_din_nxt = '0;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_gnt_nxt   = '0;
                    end
                end else if (w_c_valid) begin
                    if (w_legal) begin
                        w_state_nxt = S_BUSY;
                        w_m_cmd_nxt = {w_c_start, w_c_stop, w_c_read, w_c_write, w_c_ack_in};
                        w_m_din_nxt = w_c_din;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_err_nxt[r_idx] = 1'b1;
                    end
                end
            end
            S_BUSY: begin
                if (bus.m_al_i) begin
                    // lost the bus: someone else owns it, so no STOP of ours
                    w_m_cmd_nxt      = M_NONE;
                    w_m_din_nxt      = '0;
                    w_err_nxt[r_idx] = 1'b1;
                    w_open_nxt       = 1'b0;
                    w_gnt_nxt        = '0;
                    w_state_nxt      = S_IDLE;
                end else if (bus.m_cmd_ack_i) begin
                    w_m_cmd_nxt       = M_NONE;
                    w_m_din_nxt       = '0;
                    w_done_nxt[r_idx] = 1'b1;
                    w_rd_data_nxt     = bus.m_dout_i;
                    w_ack_out_nxt     = bus.m_ack_out_i;
                    if (r_m_cmd[B_START]) begin
                        w_open_nxt = 1'b1;
                    end else if (r_m_cmd[B_STOP]) begin
                        w_open_nxt = 1'b0;
                    end
                    if (r_m_cmd[B_STOP]) begin
                        w_gnt_nxt   = '0;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_OWN;
                    end
                end else if (w_timeout) begin
                    w_m_cmd_nxt      = M_STOP;
                    w_m_din_nxt      = '0;
                    w_err_nxt[r_idx] = 1'b1;
                    w_cnt_nxt        = '0;
                    w_state_nxt      = S_FLUSH;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            S_FLUSH: begin
                if (bus.m_cmd_ack_i || bus.m_al_i || w_timeout) begin
                    w_m_cmd_nxt = M_NONE;
                    w_open_nxt  = 1'b0;
                    w_gnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_gnt_nxt   = '0;
                w_m_cmd_nxt = M_NONE;
            end
        endcase
    end

    // State and registered-output update.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_state   <= S_IDLE;
            r_ptr     <= '0;
            r_idx     <= '0;
            r_gnt     <= '0;
            r_open    <= 1'b0;
            r_cnt     <= '0;
            r_m_cmd   <= M_NONE;
            r_m_din   <= '0;
            r_done    <= '0;
            r_err     <= '0;
            r_rd_data <= '0;
            r_ack_out <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ptr     <= w_ptr_nxt;
            r_idx     <= w_idx_nxt;
            r_gnt     <= w_gnt_nxt;
            r_open    <= w_open_nxt;
            r_cnt     <= w_cnt_nxt;
            r_m_cmd   <= w_m_cmd_nxt;
            r_m_din   <= w_m_din_nxt;
            r_done    <= w_done_nxt;
            r_err     <= w_err_nxt;
            r_rd_data <= w_rd_data_nxt;
            r_ack_out <= w_ack_out_nxt;
        end
    end

    assign bus.gnt_o      = r_gnt;
    assign bus.cmd_done_o = r_done;
    assign bus.cmd_err_o  = r_err;
    assign bus.rd_data_o  = r_rd_data;
    assign bus.ack_out_o  = r_ack_out;
    assign bus.m_start_o  = r_m_cmd[4];
    assign bus.m_stop_o   = r_m_cmd[3];
    assign bus.m_read_o   = r_m_cmd[2];
    assign bus.m_write_o  = r_m_cmd[1];
    assign bus.m_ack_in_o = r_m_cmd[0];
    assign bus.m_din_o    = r_m_din;
endmodule

// File: tb/tb_i2c_byte_arbiter.sv
// Bench for i2c_byte_arbiter with two requesters and a 16-cycle timeout.
// A byte-controller model acks (or signals AL) after a short delay and
// checks written bytes against a queue; a response monitor pops expected
// done/err pulses from a scoreboard queue.
module tb_i2c_byte_arbiter;
    logic clk = 1'b0;
    logic arstn = 1'b0;
    always #5 clk = ~clk;

    i2c_byte_arbiter_if #(.N_REQ(2), .DW(8)) bus();

    i2c_byte_arbiter #(.N_REQ(2), .DATA_WIDTH(8), .TIMEOUT_CYCLES(16)) dut (
        .clk_i   (clk),
        .arstn_i (arstn),
        .bus     (bus)
    );

    typedef struct {
        bit         is_err;
        int         idx;
        bit         chk_data;
        logic [7:0] data;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] exp_din[$];
    int         errors = 0;
    int         checks = 0;
    bit         ack_en = 1'b1;
    bit         al_mode = 1'b0;
    int         ack_dly = 1;
    logic [7:0] slave_byte = 8'h00;
    int         stop_cnt = 0;
    int         m_active = 0;
    logic       last_ack_in = 1'b0;

    task automatic tick;
        @(negedge clk);
        #2;
    endtask

    task automatic push_resp(input bit is_err, input int idx, input bit chk, input logic [7:0] d);
        exp_t e;
        e.is_err   = is_err;
        e.idx      = idx;
        e.chk_data = chk;
        e.data     = d;
        sb.push_back(e);
    endtask

    task automatic send(input int idx, input bit st, input bit sp, input bit rd, input bit wr,
                        input bit ai, input logic [7:0] din);
        bus.cmd_start_i[idx]        = st;
        bus.cmd_stop_i[idx]         = sp;
        bus.cmd_read_i[idx]         = rd;
        bus.cmd_write_i[idx]        = wr;
        bus.cmd_ack_in_i[idx]       = ai;
        bus.cmd_din_i[idx*8 +: 8]   = din;
        bus.cmd_valid_i[idx]        = 1'b1;
        tick();
        bus.cmd_valid_i[idx]        = 1'b0;
    endtask

    task automatic wait_resp(output int n);
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_gnt(input logic [1:0] v);
        int n;
        n = 0;
        while (bus.gnt_o !== v && n < 100) begin
            tick();
            n++;
        end
    endtask

    // Response monitor: every done/err pulse must match the head of sb.
    task automatic monitor_resp;
        exp_t e;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (bus.cmd_done_o[i] === 1'b1 || bus.cmd_err_o[i] === 1'b1) begin
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL resp_unexpected idx=%0d done=%b err=%b, required no pulse",
                                 i, bus.cmd_done_o[i], bus.cmd_err_o[i]);
                    end else begin
                        e = sb.pop_front();
                        if (bus.cmd_err_o[i] !== e.is_err || i != e.idx ||
                            bus.cmd_done_o[i] === bus.cmd_err_o[i] ||
                            (e.chk_data && bus.rd_data_o !== e.data)) begin
                            errors++;
                            $display("FAIL resp idx=%0d err=%b done=%b data=%h, required idx=%0d err=%b data=%h",
                                     i, bus.cmd_err_o[i], bus.cmd_done_o[i], bus.rd_data_o,
                                     e.idx, e.is_err, e.data);
                        end
                    end
                end
            end
        end
    endtask

    // Byte-controller model: ack (or AL) after ack_dly cycles of activity.
    task automatic slave_model;
        logic busy;
        int   dly_cnt;
        logic [7:0] d;
        dly_cnt         = 0;
        bus.m_cmd_ack_i = 1'b0;
        bus.m_al_i      = 1'b0;
        bus.m_ack_out_i = 1'b0;
        bus.m_dout_i    = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            if (bus.m_cmd_ack_i || bus.m_al_i) begin
                bus.m_cmd_ack_i = 1'b0;
                bus.m_al_i      = 1'b0;
                dly_cnt         = 0;
            end else begin
                busy = bus.m_start_o | bus.m_stop_o | bus.m_read_o | bus.m_write_o;
                if (busy === 1'b1) m_active++;
                if (ack_en && busy === 1'b1) begin
                    if (dly_cnt >= ack_dly) begin
                        dly_cnt = 0;
                        if (al_mode) begin
                            bus.m_al_i = 1'b1;
                        end else begin
                            bus.m_dout_i    = slave_byte;
                            bus.m_ack_out_i = 1'b0;
                            bus.m_cmd_ack_i = 1'b1;
                            last_ack_in     = bus.m_ack_in_o;
                            if (bus.m_stop_o && !bus.m_write_o && !bus.m_read_o && !bus.m_start_o)
                                stop_cnt++;
                            if (bus.m_write_o) begin
                                checks++;
                                if (exp_din.size() == 0) begin
                                    errors++;
                                    $display("FAIL m_din_unexpected got=%h, required no write", bus.m_din_o);
                                end else begin
                                    d = exp_din.pop_front();
                                    if (bus.m_din_o !== d) begin
                                        errors++;
                                        $display("FAIL m_din got=%h required=%h", bus.m_din_o, d);
                                    end
                                end
                            end
                        end
                    end else begin
                        dly_cnt++;
                    end
                end else begin
                    dly_cnt = 0;
                end
            end
        end
    endtask

    task automatic test_reset;
        arstn = 1'b0;
        repeat (3) tick();
        checks++;
        if (bus.gnt_o !== 2'b00) begin errors++; $display("FAIL reset_gnt got=%b required=00", bus.gnt_o); end
        checks++;
        if ({bus.cmd_done_o, bus.cmd_err_o} !== 4'b0) begin
            errors++; $display("FAIL reset_pulses got=%b required=0000", {bus.cmd_done_o, bus.cmd_err_o});
        end
        checks++;
        if ({bus.m_start_o, bus.m_stop_o, bus.m_read_o, bus.m_write_o, bus.m_ack_in_o, bus.m_din_o} !== 13'b0) begin
            errors++; $display("FAIL reset_m_cmd got=%b%b%b%b%b din=%h required all 0", bus.m_start_o,
                               bus.m_stop_o, bus.m_read_o, bus.m_write_o, bus.m_ack_in_o, bus.m_din_o);
        end
        checks++;
        if ({bus.rd_data_o, bus.ack_out_o} !== 9'b0) begin
            errors++; $display("FAIL reset_rd got=%h ack=%b required 0", bus.rd_data_o, bus.ack_out_o);
        end
        arstn = 1'b1;
        tick();
        checks++;
        if (bus.gnt_o !== 2'b00) begin errors++; $display("FAIL idle_no_req got=%b required=00", bus.gnt_o); end
    endtask

    task automatic test_single_write;
        logic [7:0] tab_din[3] = '{8'hE8, 8'h01, 8'h0B};
        bit         tab_st[3]  = '{1'b1, 1'b0, 1'b0};
        bit         tab_sp[3]  = '{1'b0, 1'b0, 1'b1};
        int n;
        bus.req_i = 2'b01;
        wait_gnt(2'b01);
        checks++;
        if (bus.gnt_o !== 2'b01) begin errors++; $display("FAIL single_gnt got=%b required=01", bus.gnt_o); end
        for (int k = 0; k < 3; k++) begin
            push_resp(1'b0, 0, 1'b0, 8'h00);
            exp_din.push_back(tab_din[k]);
            send(0, tab_st[k], tab_sp[k], 1'b0, 1'b1, 1'b0, tab_din[k]);
            wait_resp(n);
            checks++;
            if (sb.size() != 0) begin errors++; $display("FAIL single_done%0d pending=%0d required=0", k, sb.size()); end
            if (k < 2) begin
                checks++;
                if (bus.gnt_o !== 2'b01) begin errors++; $display("FAIL single_gnt_held%0d got=%b required=01", k, bus.gnt_o); end
            end
        end
        checks++;
        if (bus.gnt_o !== 2'b00) begin errors++; $display("FAIL single_release got=%b required=00", bus.gnt_o); end
        bus.req_i = 2'b00;
        repeat (3) tick();
        checks++;
        if (bus.gnt_o !== 2'b00 || exp_din.size() != 0) begin
            errors++; $display("FAIL single_idle gnt=%b din_left=%0d required 00/0", bus.gnt_o, exp_din.size());
        end
    endtask

    task automatic test_fairness_read;
        int n;
        arstn = 1'b0;
        bus.req_i = 2'b11;
        tick();
        arstn = 1'b1;
        wait_gnt(2'b01);
        checks++;
        if (bus.gnt_o !== 2'b01) begin errors++; $display("FAIL fair_first got=%b required=01", bus.gnt_o); end
        push_resp(1'b0, 0, 1'b0, 8'h00); exp_din.push_back(8'hA0);
        send(0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA0);
        wait_resp(n);
        push_resp(1'b0, 0, 1'b0, 8'h00); exp_din.push_back(8'h55);
        send(0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h55);
        wait_resp(n);
        bus.req_i = 2'b10;
        wait_gnt(2'b10);
        checks++;
        if (bus.gnt_o !== 2'b10) begin errors++; $display("FAIL fair_second got=%b required=10", bus.gnt_o); end
        slave_byte = 8'h5A;
        push_resp(1'b0, 1, 1'b0, 8'h00); exp_din.push_back(8'hA1);
        send(1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA1);
        wait_resp(n);
        push_resp(1'b0, 1, 1'b1, 8'h5A);
        send(1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
        wait_resp(n);
        checks++;
        if (sb.size() != 0 || bus.rd_data_o !== 8'h5A) begin
            errors++; $display("FAIL read_data got=%h pending=%0d required=5a", bus.rd_data_o, sb.size());
        end
        checks++;
        if (last_ack_in !== 1'b1 || bus.ack_out_o !== 1'b0) begin
            errors++; $display("FAIL read_ack ack_in=%b ack_out=%b required 1/0", last_ack_in, bus.ack_out_o);
        end
        push_resp(1'b0, 1, 1'b0, 8'h00);
        send(1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        wait_resp(n);
        checks++;
        if (bus.gnt_o !== 2'b00) begin errors++; $display("FAIL fair_release got=%b required=00", bus.gnt_o); end
        bus.req_i = 2'b11;
        wait_gnt(2'b01);
        checks++;
        if (bus.gnt_o !== 2'b01) begin errors++; $display("FAIL fair_rr got=%b required=01", bus.gnt_o); end
        bus.req_i = 2'b00;
        wait_gnt(2'b00);
        checks++;
        if (bus.gnt_o !== 2'b00) begin errors++; $display("FAIL fair_drop got=%b required=00", bus.gnt_o); end
    endtask

    task automatic test_flush_on_drop;
        int n;
        int stop_before;
        bus.req_i = 2'b01;
        wait_gnt(2'b01);
        push_resp(1'b0, 0, 1'b0, 8'h00); exp_din.push_back(8'h50);
        send(0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h50);
        wait_resp(n);
        stop_before = stop_cnt;
        bus.req_i = 2'b00;
        tick();
        checks++;
        if (bus.m_stop_o !== 1'b1 || bus.m_write_o !== 1'b0 || bus.gnt_o !== 2'b01) begin
            errors++; $display("FAIL flush_issue stop=%b write=%b gnt=%b required 1/0/01",
                               bus.m_stop_o, bus.m_write_o, bus.gnt_o);
        end
        wait_gnt(2'b00);
        checks++;
        if (bus.gnt_o !== 2'b00 || stop_cnt != stop_before + 1) begin
            errors++; $display("FAIL flush_done gnt=%b stops=%0d required 00/%0d", bus.gnt_o, stop_cnt, stop_before + 1);
        end
    endtask

    task automatic test_timeout;
        int n;
        int stop_before;
        ack_en = 1'b0;
        bus.req_i = 2'b01;
        wait_gnt(2'b01);
        push_resp(1'b1, 0, 1'b0, 8'h00);
        send(0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h33);
        wait_resp(n);
        checks++;
        if (sb.size() != 0 || n != 16) begin
            errors++; $display("FAIL timeout_err cycles=%0d pending=%0d required 16/0", n, sb.size());
        end
        checks++;
        if (bus.m_stop_o !== 1'b1 || bus.m_write_o !== 1'b0) begin
            errors++; $display("FAIL timeout_flush stop=%b write=%b required 1/0", bus.m_stop_o, bus.m_write_o);
        end
        bus.req_i = 2'b00;
        stop_before = stop_cnt;
        ack_en = 1'b1;
        wait_gnt(2'b00);
        checks++;
        if (bus.gnt_o !== 2'b00 || stop_cnt != stop_before + 1) begin
            errors++; $display("FAIL timeout_idle gnt=%b stops=%0d required 00/%0d", bus.gnt_o, stop_cnt, stop_before + 1);
        end
    endtask

    task automatic test_arb_lost;
        int n;
        int stop_before;
        al_mode = 1'b1;
        bus.req_i = 2'b01;
        wait_gnt(2'b01);
        push_resp(1'b1, 0, 1'b0, 8'h00);
        send(0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h77);
        wait_resp(n);
        checks++;
        if (sb.size() != 0 || bus.gnt_o !== 2'b00) begin
            errors++; $display("FAIL al_release gnt=%b pending=%0d required 00/0", bus.gnt_o, sb.size());
        end
        bus.req_i = 2'b00;
        al_mode = 1'b0;
        stop_before = stop_cnt;
        repeat (4) tick();
        checks++;
        if (bus.m_stop_o !== 1'b0 || stop_cnt != stop_before || bus.gnt_o !== 2'b00) begin
            errors++; $display("FAIL al_no_flush stop=%b stops=%0d gnt=%b required 0/%0d/00",
                               bus.m_stop_o, stop_cnt, bus.gnt_o, stop_before);
        end
    endtask

    task automatic test_illegal_and_reset;
        int n;
        int act0;
        bus.req_i = 2'b10;
        wait_gnt(2'b10);
        checks++;
        if (bus.gnt_o !== 2'b10) begin errors++; $display("FAIL ill_gnt got=%b required=10", bus.gnt_o); end
        act0 = m_active;
        push_resp(1'b1, 1, 1'b0, 8'h00);
        send(1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'hAA);
        wait_resp(n);
        tick();
        checks++;
        if (sb.size() != 0 || m_active != act0 || bus.gnt_o !== 2'b10) begin
            errors++; $display("FAIL illegal_cmd pending=%0d active=%0d gnt=%b required 0/%0d/10",
                               sb.size(), m_active, bus.gnt_o, act0);
        end
        send(0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h99);
        repeat (3) tick();
        checks++;
        if (m_active != act0 || bus.gnt_o !== 2'b10) begin
            errors++; $display("FAIL nongranted_cmd active=%0d gnt=%b required %0d/10", m_active, bus.gnt_o, act0);
        end
        ack_en = 1'b0;
        send(1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h42);
        checks++;
        if (bus.m_write_o !== 1'b1 || bus.m_start_o !== 1'b1 || bus.m_din_o !== 8'h42) begin
            errors++; $display("FAIL busy_issue write=%b start=%b din=%h required 1/1/42",
                               bus.m_write_o, bus.m_start_o, bus.m_din_o);
        end
        arstn = 1'b0;
        #1;
        checks++;
        if (bus.gnt_o !== 2'b00 || {bus.cmd_done_o, bus.cmd_err_o} !== 4'b0 ||
            {bus.m_start_o, bus.m_stop_o, bus.m_read_o, bus.m_write_o, bus.m_ack_in_o} !== 5'b0 ||
            bus.m_din_o !== 8'h00 || bus.rd_data_o !== 8'h00 || bus.ack_out_o !== 1'b0) begin
            errors++; $display("FAIL busy_reset gnt=%b din=%h rd=%h write=%b required all 0",
                               bus.gnt_o, bus.m_din_o, bus.rd_data_o, bus.m_write_o);
        end
        bus.req_i = 2'b00;
        tick();
        arstn = 1'b1;
        ack_en = 1'b1;
        tick();
        checks++;
        if (bus.gnt_o !== 2'b00) begin errors++; $display("FAIL post_reset_gnt got=%b required=00", bus.gnt_o); end
    endtask

    initial begin
        bus.req_i        = '0;
        bus.cmd_valid_i  = '0;
        bus.cmd_start_i  = '0;
        bus.cmd_stop_i   = '0;
        bus.cmd_read_i   = '0;
        bus.cmd_write_i  = '0;
        bus.cmd_ack_in_i = '0;
        bus.cmd_din_i    = '0;
        fork
            monitor_resp();
            slave_model();
        join_none
        test_reset();
        test_single_write();
        test_fairness_read();
        test_flush_on_drop();
        test_timeout();
        test_arb_lost();
        test_illegal_and_reset();
        repeat (2) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule
